// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_loader
// Description : Command/byte-stream front end that packs signed elements
//               row-major into the matrix ALU operand buses and sequences
//               the start/done handshake with a wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    input  logic [2:0]                          cmd_op,
    input  logic [1:0]                          cmd_size,
    input  logic [ELEM_W-1:0]                   cmd_scalar,
    input  logic [ELEM_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                alu_done,
    output logic [2:0]                          op_code,
    output logic [1:0]                          matrix_size,
    output logic [ELEM_W-1:0]                   scalar,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]   matrix_a,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]   matrix_b,
    output logic                                alu_start,
    output logic                                busy,
    output logic                                cmd_err,
    output logic                                timeout
);

    localparam int CELLS  = MAX_DIM * MAX_DIM;
    localparam int BUS_W  = ELEM_W * CELLS;
    localparam int CNT_W  = $clog2(MAX_DIM);
    localparam int IDX_W  = $clog2(CELLS);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load_a = 3'd1;
    localparam logic [2:0] c_st_load_b = 3'd2;
    localparam logic [2:0] c_st_start  = 3'd3;
    localparam logic [2:0] c_st_wait   = 3'd4;

    localparam logic [2:0] c_op_add     = 3'b000;
    localparam logic [2:0] c_op_sub     = 3'b001;
    localparam logic [2:0] c_op_mmul    = 3'b110;
    localparam logic [2:0] c_op_invalid = 3'b111;

    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [2:0]        r_op_code;
    logic [1:0]        r_size;
    logic [ELEM_W-1:0] r_scalar;
    logic [BUS_W-1:0]  r_matrix_a;
    logic [BUS_W-1:0]  r_matrix_b;
    logic [CNT_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_col;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic [CNT_W-1:0]  w_last;
    logic [IDX_W-1:0]  w_idx;
    logic              w_accept;
    logic              w_last_elem;
    logic              w_two_op;
    logic              w_cmd_ok;
    logic              w_wait_last;

    // Bus slot uses the fixed MAX_DIM stride, not the active dimension N.
    assign w_last      = CNT_W'(r_size) + CNT_W'(1);
    assign w_idx       = IDX_W'(r_row) * IDX_W'(MAX_DIM) + IDX_W'(r_col);
    assign w_accept    = in_valid && in_ready;
    assign w_last_elem = w_accept && (r_row == w_last) && (r_col == w_last);
    assign w_two_op    = (r_op_code == c_op_add) || (r_op_code == c_op_sub) ||
                         (r_op_code == c_op_mmul);
    assign w_cmd_ok    = cmd_valid && (cmd_op != c_op_invalid);
    assign w_wait_last = (r_wait_cnt == c_wait_last);

    assign op_code     = r_op_code;
    assign matrix_size = r_size;
    assign scalar      = r_scalar;
    assign matrix_a    = r_matrix_a;
    assign matrix_b    = r_matrix_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (w_cmd_ok) w_next = c_st_load_a;
            c_st_load_a: if (w_last_elem) w_next = w_two_op ? c_st_load_b : c_st_start;
            c_st_load_b: if (w_last_elem) w_next = c_st_start;
            c_st_start:  w_next = c_st_wait;
            c_st_wait:   if (alu_done || w_wait_last) w_next = c_st_idle;
            default:     w_next = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        alu_start = 1'b0;
        cmd_err   = 1'b0;
        timeout   = 1'b0;
        case (r_state)
            c_st_idle:   cmd_err = cmd_valid && (cmd_op == c_op_invalid);
            c_st_load_a,
            c_st_load_b: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            c_st_start: begin
                alu_start = 1'b1;
                busy      = 1'b1;
            end
            c_st_wait: begin
                busy    = 1'b1;
                timeout = !alu_done && w_wait_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_code  <= '0;
            r_size     <= '0;
            r_scalar   <= '0;
            r_matrix_a <= '0;
            r_matrix_b <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_cmd_ok) begin
                        r_op_code  <= cmd_op;
                        r_size     <= cmd_size;
                        r_scalar   <= cmd_scalar;
                        r_matrix_a <= '0;
                        r_matrix_b <= '0;
                        r_row      <= '0;
                        r_col      <= '0;
                    end
                end
                c_st_load_a,
                c_st_load_b: begin
                    if (w_accept) begin
                        for (int i = 0; i < CELLS; i++) begin
                            if (w_idx == IDX_W'(i)) begin
                                if (r_state == c_st_load_a) begin
                                    r_matrix_a[i*ELEM_W +: ELEM_W] <= in_data;
                                end else begin
                                    r_matrix_b[i*ELEM_W +: ELEM_W] <= in_data;
                                end
                            end
                        end
                        // Wrapping both counters on the last element leaves them at 0 for LOAD_B.
                        if (r_col == w_last) begin
                            r_col <= '0;
                            r_row <= (r_row == w_last) ? '0 : r_row + CNT_W'(1);
                        end else begin
                            r_col <= r_col + CNT_W'(1);
                        end
                    end
                end
                c_st_start: r_wait_cnt <= '0;
                c_st_wait: begin
                    if (!alu_done) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// Testbench for matrix_loader: directed scenarios plus randomized commands
// checked against a row-major packing model of the operand buses.
module tb_matrix_loader;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic [2:0]   cmd_op;
    logic [1:0]   cmd_size;
    logic [7:0]   cmd_scalar;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         alu_done;
    logic [2:0]   op_code;
    logic [1:0]   matrix_size;
    logic [7:0]   scalar;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic         alu_start;
    logic         busy;
    logic         cmd_err;
    logic         timeout;

    int total = 0;
    int bad   = 0;
    logic [7:0] stream_d [50];
    logic [2:0] last_op = 3'd0;

    matrix_loader #(.ELEM_W(8), .MAX_DIM(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_size(cmd_size), .cmd_scalar(cmd_scalar), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .alu_done(alu_done),
        .op_code(op_code), .matrix_size(matrix_size), .scalar(scalar),
        .matrix_a(matrix_a), .matrix_b(matrix_b), .alu_start(alu_start),
        .busy(busy), .cmd_err(cmd_err), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: stream element k of an NxN operand is (k/N, k%N) on a 5-wide grid.
    function automatic logic [199:0] pack(input int n, input int base);
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                m[(5*r + c)*8 +: 8] = stream_d[base + r*n + c];
        return m;
    endfunction

    function automatic bit is_two_op(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b110);
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) stream_d[i] = 8'($urandom);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] sc);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_size   = sz;
        cmd_scalar = sc;
        tick();
        cmd_valid  = 1'b0;
        last_op    = op;
    endtask

    // Streams stream_d, keeping in_valid offered past the end to expose over-acceptance.
    task automatic drive_stream(input int n, input int mode, output int hs, output int cyc, output int stl);
        int idx;
        bit v;
        idx = 0; hs = 0; cyc = 0; stl = 0;
        while (alu_start !== 1'b1 && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_data  = (idx < n) ? stream_d[idx] : 8'hA5;
            #1;
            if (in_valid && in_ready) begin
                hs++;
                idx++;
            end else if (!in_valid) begin
                stl++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
        total++; if (matrix_a !== '0 || matrix_b !== '0) begin bad++; $display("FAIL rst_mats got a=%0h b=%0h exp=0", matrix_a, matrix_b); end
        total++; if ({alu_start, timeout, cmd_err, op_code, matrix_size, scalar} !== '0) begin
            bad++; $display("FAIL rst_ctrl got=%0h exp=0", {alu_start, timeout, cmd_err, op_code, matrix_size, scalar});
        end
        rst = 1'b0;
        tick();
        send_cmd(3'b000, 2'b00, 8'h11);
        in_valid = 1'b1; in_data = 8'h3C;
        tick(); tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1 || matrix_a === '0) begin bad++; $display("FAIL pre_rst_load busy=%0h a=%0h exp busy=1 a!=0", busy, matrix_a); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL async_rst got busy=%0h rdy=%0h exp=0", busy, in_ready); end
        total++; if (matrix_a !== '0 || op_code !== 3'd0 || scalar !== 8'd0) begin
            bad++; $display("FAIL async_rst_data got a=%0h op=%0h sc=%0h exp=0", matrix_a, op_code, scalar);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_2x2();
        int hs, cyc, stl;
        for (int i = 0; i < 8; i++) stream_d[i] = 8'(i + 1);
        send_cmd(3'b000, 2'b00, 8'h00);
        drive_stream(8, 0, hs, cyc, stl);
        total++; if (hs !== 8) begin bad++; $display("FAIL add_handshakes got=%0d exp=8", hs); end
        total++; if (cyc !== 8 || alu_start !== 1'b1) begin bad++; $display("FAIL add_latency got cyc=%0d start=%0h exp 8/1", cyc, alu_start); end
        total++; if (matrix_a[7:0] !== 8'd1 || matrix_a[15:8] !== 8'd2 || matrix_a[47:40] !== 8'd3 || matrix_a[55:48] !== 8'd4) begin
            bad++; $display("FAIL add_a_bytes got=%0h", matrix_a);
        end
        total++; if (matrix_a !== pack(2, 0)) begin bad++; $display("FAIL add_a got=%0h exp=%0h", matrix_a, pack(2, 0)); end
        total++; if (matrix_b !== pack(2, 4)) begin bad++; $display("FAIL add_b got=%0h exp=%0h", matrix_b, pack(2, 4)); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_start_rdy got=%0h exp=0", in_ready); end
        alu_done = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || alu_start !== 1'b0) begin bad++; $display("FAIL add_done_in_start got busy=%0h start=%0h exp 1/0", busy, alu_start); end
        tick();
        alu_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_to_idle got busy=%0h exp=0", busy); end
        total++; if (matrix_a !== pack(2, 0) || op_code !== 3'b000) begin bad++; $display("FAIL add_hold got a=%0h op=%0h", matrix_a, op_code); end
    endtask

    task automatic test_det_3x3_stalls();
        int hs, cyc, stl;
        for (int i = 0; i < 9; i++) stream_d[i] = 8'(-(i + 1));
        send_cmd(3'b101, 2'b01, 8'h00);
        drive_stream(9, 1, hs, cyc, stl);
        total++; if (hs !== 9) begin bad++; $display("FAIL det_handshakes got=%0d exp=9", hs); end
        total++; if (cyc !== 9 + stl || alu_start !== 1'b1) begin bad++; $display("FAIL det_latency got=%0d exp=%0d", cyc, 9 + stl); end
        total++; if (matrix_a[103:96] !== 8'hF7) begin bad++; $display("FAIL det_last_elem got=%0h exp=f7", matrix_a[103:96]); end
        total++; if (matrix_a !== pack(3, 0)) begin bad++; $display("FAIL det_a got=%0h exp=%0h", matrix_a, pack(3, 0)); end
        total++; if (matrix_b !== '0) begin bad++; $display("FAIL det_b got=%0h exp=0", matrix_b); end
        alu_done = 1'b0;
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL det_idle got busy=%0h exp=0", busy); end
    endtask

    task automatic test_mult_5x5();
        int hs, cyc, stl;
        fill_random(50);
        send_cmd(3'b110, 2'b11, 8'h00);
        drive_stream(50, 2, hs, cyc, stl);
        total++; if (hs !== 50) begin bad++; $display("FAIL mmul_handshakes got=%0d exp=50", hs); end
        total++; if (cyc !== 50 + stl || alu_start !== 1'b1) begin bad++; $display("FAIL mmul_latency got=%0d exp=%0d", cyc, 50 + stl); end
        total++; if (matrix_a[199:192] !== stream_d[24] || matrix_b[199:192] !== stream_d[49]) begin
            bad++; $display("FAIL mmul_top got a=%0h b=%0h exp a=%0h b=%0h", matrix_a[199:192], matrix_b[199:192], stream_d[24], stream_d[49]);
        end
        total++; if (matrix_a !== pack(5, 0) || matrix_b !== pack(5, 25)) begin bad++; $display("FAIL mmul_mats got a=%0h b=%0h", matrix_a, matrix_b); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mmul_rdy got=%0h exp=0", in_ready); end
        alu_done = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL mmul_wait_busy cycle=%0d got=%0h exp=1", i, busy); end
            tick();
        end
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mmul_idle got busy=%0h exp=0", busy); end
    endtask

    task automatic test_invalid_cmd();
        int hs, cyc, stl;
        logic [2:0] prev_op;
        logic [7:0] sc;
        prev_op   = last_op;
        cmd_valid = 1'b1; cmd_op = 3'b111; cmd_size = 2'b10; cmd_scalar = 8'h42;
        #1;
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL inv_err got=%0h exp=1", cmd_err); end
        tick();
        cmd_valid = 1'b0;
        #1;
        total++; if (cmd_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL inv_stay got err=%0h busy=%0h exp 0/0", cmd_err, busy); end
        total++; if (op_code !== prev_op) begin bad++; $display("FAIL inv_op_held got=%0h exp=%0h", op_code, prev_op); end
        tick();
        sc = 8'($urandom);
        send_cmd(3'b011, 2'b00, sc);
        cmd_valid = 1'b1; cmd_op = 3'b111;
        #1;
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL busy_cmd_err got=%0h exp=0", cmd_err); end
        tick();
        cmd_op = 3'b000; cmd_size = 2'b11; cmd_scalar = ~sc;
        tick();
        cmd_valid = 1'b0;
        total++; if (op_code !== 3'b011 || matrix_size !== 2'b00 || scalar !== sc || busy !== 1'b1) begin
            bad++; $display("FAIL busy_cmd_ignored got op=%0h sz=%0h sc=%0h busy=%0h", op_code, matrix_size, scalar, busy);
        end
        fill_random(4);
        drive_stream(4, 0, hs, cyc, stl);
        total++; if (hs !== 4 || cyc !== 4) begin bad++; $display("FAIL opp_single got hs=%0d cyc=%0d exp 4/4", hs, cyc); end
        total++; if (matrix_a !== pack(2, 0) || matrix_b !== '0) begin bad++; $display("FAIL opp_mats got a=%0h b=%0h", matrix_a, matrix_b); end
        alu_done = 1'b1;
        tick(); tick();
        alu_done = 1'b0;
    endtask

    task automatic test_timeout();
        int hs, cyc, stl, k;
        logic [7:0] sc;
        sc = 8'($urandom);
        fill_random(16);
        send_cmd(3'b100, 2'b10, sc);
        drive_stream(16, 2, hs, cyc, stl);
        total++; if (hs !== 16 || alu_start !== 1'b1) begin bad++; $display("FAIL to_load got hs=%0d start=%0h exp 16/1", hs, alu_start); end
        alu_done = 1'b0;
        k = 0;
        while (timeout !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        total++; if (k !== 16) begin bad++; $display("FAIL to_delay got=%0d exp=16", k); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy got=%0h exp=1", busy); end
        tick();
        total++; if (timeout !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_pulse got to=%0h busy=%0h exp 0/0", timeout, busy); end
        total++; if (matrix_a !== pack(4, 0) || scalar !== sc || op_code !== 3'b100 || matrix_size !== 2'b10) begin
            bad++; $display("FAIL to_hold got a=%0h sc=%0h op=%0h", matrix_a, scalar, op_code);
        end
    endtask

    task automatic test_random();
        int hs, cyc, stl, n, tot, d;
        logic [2:0] op;
        logic [1:0] sz;
        logic [7:0] sc;
        for (int it = 0; it < 8; it++) begin
            op  = 3'($urandom_range(0, 6));
            sz  = 2'($urandom_range(0, 3));
            sc  = 8'($urandom);
            n   = int'(sz) + 2;
            tot = is_two_op(op) ? 2*n*n : n*n;
            fill_random(tot);
            send_cmd(op, sz, sc);
            drive_stream(tot, 2, hs, cyc, stl);
            total++; if (hs !== tot || cyc !== tot + stl) begin
                bad++; $display("FAIL rnd_count it=%0d got hs=%0d cyc=%0d exp %0d/%0d", it, hs, cyc, tot, tot + stl);
            end
            total++; if (matrix_a !== pack(n, 0)) begin bad++; $display("FAIL rnd_a it=%0d got=%0h exp=%0h", it, matrix_a, pack(n, 0)); end
            total++; if (matrix_b !== (is_two_op(op) ? pack(n, n*n) : 200'd0)) begin bad++; $display("FAIL rnd_b it=%0d got=%0h", it, matrix_b); end
            total++; if (op_code !== op || matrix_size !== sz || scalar !== sc) begin
                bad++; $display("FAIL rnd_regs it=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", it, op_code, matrix_size, scalar, op, sz, sc);
            end
            d = $urandom_range(0, 8);
            alu_done = 1'b0;
            tick();
            repeat (d) tick();
            alu_done = 1'b1;
            tick();
            alu_done = 1'b0;
            total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL rnd_done it=%0d got busy=%0h to=%0h exp 0/0", it, busy, timeout); end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0; cmd_scalar = '0;
        in_data = '0; in_valid = 1'b0; alu_done = 1'b0;
        tick(); tick();
        test_reset();
        test_add_2x2();
        test_det_3x3_stalls();
        test_mult_5x5();
        test_invalid_cmd();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
